i2c_bit_sequencer: RTL and testbench
====================================

Name: i2c_bit_sequencer

Overview:
- Registered bit-level engine of the I2C master. Holds state_reg/ctr_reg and advances through the k_* phase states, applying the same next-state rule as the combinational next_* helpers: a phase ends when ctr_reg == divisor; on that edge the state advances and ctr resets to 0.
- Upstream, the byte/transaction layer issues single-bit commands.
- Downstream, it drives the open-drain SCL/SDA enables.

Parameters:
- DIV_W, 16, width of the phase counter and the divisor.
- SYNC_STAGES, 2, synchroniser depth on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- dbl_clock_divisor  input  DIV_W  phase length minus one, in clk cycles; latched when a command is accepted
- cmd_valid  input  1  command request
- cmd  input  2  00 START, 01 STOP, 10 WRITE, 11 READ
- cmd_data  input  1  bit to transmit (WRITE only)
- cmd_ready  output  1  high in k_idle and k_held only
- done  output  1  one-cycle pulse when a command completes
- err  output  1  one-cycle pulse when an illegal command is consumed
- rx_bit  output  1  SDA sampled in the last READ/WRITE; valid with done, held until the next done
- busy  output  1  high in every state except k_idle
- scl_oe  output  1  1 = pull SCL low
- sda_oe  output  1  1 = pull SDA low
- scl_in  input  1  raw SCL pin
- sda_in  input  1  raw SDA pin

Behaviour:
- Reset (asynchronous): state k_idle, ctr 0, scl_oe = sda_oe = 0, done = err = rx_bit = 0, synchronisers cleared to 1. Lines are released immediately, including mid-transfer.
- Outputs are registered and decoded from state_next.
- Handshake: a command is accepted on an edge with cmd_valid & cmd_ready. On acceptance the divisor is latched, ctr goes to 0, and the state moves to the first phase of the command. No command is buffered.
- Phase rule: ctr increments each cycle. When ctr == latched divisor, the state advances and ctr goes to 0. Each phase therefore lasts divisor+1 cycles; divisor 0 gives 1-cycle phases.
- Clock stretching: in phases that release SCL (k_start1, k_bit2, k_stop2), ctr holds at 0 until synced scl_in == 1.
- Phase outputs (scl_oe/sda_oe):
  - k_idle 0/0
  - k_held 1/0
  - k_restart 1/0
  - k_start1 0/0
  - k_start2 0/1
  - k_start3 1/1
  - k_bit1 1/d
  - k_bit2 0/d
  - k_bit3 1/d, where d = ~cmd_data for WRITE and 0 for READ
  - k_stop1 1/1
  - k_stop2 0/1
  - k_stop3 0/0
- Transitions:
  - START in k_idle: k_start1 -> k_start2 -> k_start3 -> k_held.
  - START in k_held (repeated start): k_restart -> k_start1 -> k_start2 -> k_start3 -> k_held.
  - WRITE/READ in k_held: k_bit1 -> k_bit2 -> k_bit3 -> k_held.
  - STOP in k_held: k_stop1 -> k_stop2 -> k_stop3 -> k_idle.
  - STOP/WRITE/READ in k_idle: consumed, err pulses next cycle, state unchanged, no line activity.
- rx_bit captures synced sda_in on the terminal edge of k_bit2.
- done asserts in the first cycle of k_held/k_idle after a command. A new command may be accepted in that same cycle.
- Arbitration loss is not detected in this block.
- State encoding is 4 bits; unused codes go to k_idle.

Test Plan:
- Reset, then divisor=3, START from idle -> cmd_ready drops on the accept edge; sda_oe rises at cycle 4, scl_oe at cycle 8; done pulses at cycle 12 with state k_held and cmd_ready=1.
- From k_held, WRITE data=0, divisor=3, sda_in tied low -> sda_oe=1 for 12 cycles; scl_oe low-window spans cycles 4..7; done at cycle 12; rx_bit=0.
- READ with sda_in high and scl_in held low for 10 cycles during k_bit2 -> k_bit2 stretched to 14 cycles; rx_bit=1; done at cycle 22.
- START while held, divisor=0 -> k_restart, k_start1, k_start2, k_start3 one cycle each; done at cycle 4.
- STOP in k_idle -> err pulses once, done stays 0, scl_oe = sda_oe = 0, busy=0.
- Assert rst_n low mid k_bit2 -> scl_oe = sda_oe = 0 immediately without a clock edge; after release, state is k_idle and cmd_ready=1.

Source files
------------

// File: rtl/i2c_bit_sequencer.sv
// Bit-level engine of the I2C master: sequences START/STOP/WRITE/READ into
// timed phases on the open-drain SCL/SDA enables, with SCL stretching support.
module i2c_bit_sequencer #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] dbl_clock_divisor,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  input  logic             cmd_data,
  output logic             cmd_ready,
  output logic             done,
  output logic             err,
  output logic             rx_bit,
  output logic             busy,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_in,
  input  logic             sda_in
);

  typedef enum logic [3:0] {
    k_idle    = 4'd0,
    k_held    = 4'd1,
    k_restart = 4'd2,
    k_start1  = 4'd3,
    k_start2  = 4'd4,
    k_start3  = 4'd5,
    k_bit1    = 4'd6,
    k_bit2    = 4'd7,
    k_bit3    = 4'd8,
    k_stop1   = 4'd9,
    k_stop2   = 4'd10,
    k_stop3   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_t;

  localparam logic [DIV_W-1:0] CTR_ONE = DIV_W'(1);

  state_t                 state_q, state_d;
  logic [DIV_W-1:0]       ctr_q, ctr_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   sda_bit_q, sda_bit_d;
  logic                   sample_q, sample_d;
  logic                   rx_bit_q, rx_bit_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   scl_oe_q, scl_oe_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;

  cmd_t cmd_in;
  logic scl_s, sda_s, accept, stall, phase_end;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    cmd_in     = cmd_t'(cmd);
  end

  // Phases that release SCL wait at ctr 0 until the line is seen high.
  always_comb begin
    accept    = cmd_valid && ((state_q == k_idle) || (state_q == k_held));
    stall     = ((state_q == k_start1) || (state_q == k_bit2) || (state_q == k_stop2))
                && (ctr_q == '0) && !scl_s;
    phase_end = !stall && (ctr_q == div_q);
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    div_d     = div_q;
    sda_bit_d = sda_bit_q;
    sample_d  = sample_q;
    rx_bit_d  = rx_bit_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      k_idle: begin
        if (accept) begin
          if (cmd_in == CMD_START) begin
            state_d = k_start1;
            div_d   = dbl_clock_divisor;
            ctr_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      k_held: begin
        if (accept) begin
          div_d = dbl_clock_divisor;
          ctr_d = '0;
          case (cmd_in)
            CMD_START: state_d = k_restart;
            CMD_STOP:  state_d = k_stop1;
            CMD_WRITE: begin
              state_d   = k_bit1;
              sda_bit_d = ~cmd_data;
            end
            default: begin
              state_d   = k_bit1;
              sda_bit_d = 1'b0;
            end
          endcase
        end
      end
      k_restart, k_start1, k_start2, k_start3, k_bit1, k_bit2, k_bit3,
      k_stop1, k_stop2, k_stop3: begin
        if (phase_end) begin
          ctr_d = '0;
          case (state_q)
            k_restart: state_d = k_start1;
            k_start1:  state_d = k_start2;
            k_start2:  state_d = k_start3;
            k_start3: begin
              state_d = k_held;
              done_d  = 1'b1;
            end
            k_bit1: state_d = k_bit2;
            k_bit2: begin
              state_d  = k_bit3;
              sample_d = sda_s;
            end
            k_bit3: begin
              state_d  = k_held;
              done_d   = 1'b1;
              rx_bit_d = sample_q;
            end
            k_stop1: state_d = k_stop2;
            k_stop2: state_d = k_stop3;
            k_stop3: begin
              state_d = k_idle;
              done_d  = 1'b1;
            end
            default: state_d = k_idle;
          endcase
        end else if (!stall) begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      default: begin
        state_d = k_idle;
        ctr_d   = '0;
      end
    endcase
  end

  // Line enables and status are registered from the upcoming state.
  always_comb begin
    scl_oe_d    = 1'b0;
    sda_oe_d    = 1'b0;
    busy_d      = (state_d != k_idle);
    cmd_ready_d = (state_d == k_idle) || (state_d == k_held);
    case (state_d)
      k_held:    scl_oe_d = 1'b1;
      k_restart: scl_oe_d = 1'b1;
      k_start2:  sda_oe_d = 1'b1;
      k_start3: begin
        scl_oe_d = 1'b1;
        sda_oe_d = 1'b1;
      end
      k_bit1: begin
        scl_oe_d = 1'b1;
        sda_oe_d = sda_bit_d;
      end
      k_bit2:  sda_oe_d = sda_bit_d;
      k_bit3: begin
        scl_oe_d = 1'b1;
        sda_oe_d = sda_bit_d;
      end
      k_stop1: begin
        scl_oe_d = 1'b1;
        sda_oe_d = 1'b1;
      end
      k_stop2: sda_oe_d = 1'b1;
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= k_idle;
      ctr_q       <= '0;
      div_q       <= '0;
      sda_bit_q   <= 1'b0;
      sample_q    <= 1'b0;
      rx_bit_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      div_q       <= div_d;
      sda_bit_q   <= sda_bit_d;
      sample_q    <= sample_d;
      rx_bit_q    <= rx_bit_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rx_bit    = rx_bit_q;
  assign busy      = busy_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Bench for i2c_bit_sequencer: directed table, stretch/reset sequences and
// random commands checked cycle-by-cycle against a phase-list reference model.
module tb_i2c_bit_sequencer;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dbl_clock_divisor = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = '0;
  logic        cmd_data = 1'b0;
  logic        cmd_ready, done, err, rx_bit, busy, scl_oe, sda_oe;
  logic        scl_in = 1'b1;
  logic        sda_in = 1'b1;

  int tests = 0;
  int fails = 0;

  bit   m_held = 1'b0;
  logic m_rx   = 1'b0;

  typedef struct {
    logic [1:0]  c;
    logic        d;
    logic [15:0] dv;
    logic        s;
    int          exp_done;
    logic        exp_rx;
  } vec_t;

  vec_t tbl[10];

  i2c_bit_sequencer #(.DIV_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .dbl_clock_divisor(dbl_clock_divisor),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .done(done), .err(err), .rx_bit(rx_bit),
    .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_in(scl_in), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Packed as {scl_oe, sda_oe, done, err, busy, cmd_ready, rx_bit}.
  task automatic check7(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {scl_oe, sda_oe, done, err, busy, cmd_ready, rx_bit};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (scl,sda,done,err,busy,rdy,rx) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check7("steady", {m_held, 1'b0, 1'b0, 1'b0, m_held, 1'b1, m_rx});
    end
  endtask

  // Reference: a command is a list of (scl,sda) phases, each divisor+1 cycles long.
  task automatic run_cmd(input logic [1:0] c, input logic d, input logic [15:0] dv,
                         input logic s, output int done_at);
    logic [1:0] ph[$];
    logic [1:0] fin;
    logic       eff, db, new_rx;
    bit         next_held;
    int         per, n;
    logic [6:0] e;
    done_at   = -1;
    eff       = (c == C_WRITE) ? (s & d) : s;
    new_rx    = m_rx;
    next_held = m_held;
    if (c == C_START) begin
      if (m_held) ph.push_back(2'b10);
      ph.push_back(2'b00);
      ph.push_back(2'b01);
      ph.push_back(2'b11);
      next_held = 1'b1;
    end else if (m_held && c == C_STOP) begin
      ph.push_back(2'b11);
      ph.push_back(2'b01);
      ph.push_back(2'b00);
      next_held = 1'b0;
    end else if (m_held) begin
      db = (c == C_WRITE) ? ~d : 1'b0;
      ph.push_back({1'b1, db});
      ph.push_back({1'b0, db});
      ph.push_back({1'b1, db});
      new_rx = eff;
    end
    fin = next_held ? 2'b10 : 2'b00;

    cmd_valid = 1'b1;
    cmd = c;
    cmd_data = d;
    dbl_clock_divisor = dv;
    sda_in = eff;
    @(posedge clk);

    if (ph.size() == 0) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      check7("illegal_err", {2'b00, 1'b0, 1'b1, 1'b0, 1'b1, m_rx});
      @(negedge clk);
      check7("illegal_clear", {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, m_rx});
      return;
    end

    per = int'(dv) + 1;
    n   = ph.size() * per;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
      if (k < n) e = {ph[k / per], 1'b0, 1'b0, 1'b1, 1'b0, m_rx};
      else       e = {fin, 1'b1, 1'b0, next_held, 1'b1, new_rx};
      check7("cycle", e);
      if (done === 1'b1 && done_at < 0) done_at = k;
    end
    m_held = next_held;
    m_rx   = new_rx;
  endtask

  initial begin
    int         da, lows, gap;
    logic [1:0] rc;
    logic       rd, rs;
    logic [15:0] rdv;

    tbl[0] = '{C_START, 1'b0, 16'd3, 1'b1, 12, 1'b0};
    tbl[1] = '{C_WRITE, 1'b0, 16'd3, 1'b0, 12, 1'b0};
    tbl[2] = '{C_WRITE, 1'b1, 16'd1, 1'b1, 6,  1'b1};
    tbl[3] = '{C_READ,  1'b0, 16'd0, 1'b0, 3,  1'b0};
    tbl[4] = '{C_START, 1'b0, 16'd0, 1'b1, 4,  1'b0};
    tbl[5] = '{C_READ,  1'b0, 16'd2, 1'b1, 9,  1'b1};
    tbl[6] = '{C_STOP,  1'b0, 16'd1, 1'b1, 6,  1'b1};
    tbl[7] = '{C_STOP,  1'b0, 16'd3, 1'b1, -1, 1'b1};
    tbl[8] = '{C_WRITE, 1'b1, 16'd3, 1'b1, -1, 1'b1};
    tbl[9] = '{C_START, 1'b0, 16'd0, 1'b1, 3,  1'b1};

    #12;
    check7("reset_state", 7'b0000010);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check7("after_reset", 7'b0000010);

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].c, tbl[i].d, tbl[i].dv, tbl[i].s, da);
      check($sformatf("tbl%0d_done_at", i), da, tbl[i].exp_done);
      check($sformatf("tbl%0d_rx", i), {31'd0, rx_bit}, {31'd0, tbl[i].exp_rx});
    end

    // READ with SCL held low by a slave: synced low covers the first 10 cycles of the bit2 phase.
    cmd_valid = 1'b1;
    cmd = C_READ;
    dbl_clock_divisor = 16'd3;
    sda_in = 1'b1;
    @(posedge clk);
    da = -1;
    lows = 0;
    for (int k = 0; k < 40 && da < 0; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
      if (k == 2) scl_in = 1'b0;
      if (k == 12) scl_in = 1'b1;
      if (done === 1'b1) da = k;
      else if (scl_oe === 1'b0) lows++;
    end
    check("stretch_done_at", da, 22);
    check("stretch_scl_low", lows, 14);
    check("stretch_rx", {31'd0, rx_bit}, 32'd1);
    m_rx = 1'b1;

    for (int i = 0; i < 60; i++) begin
      rc = 2'($urandom_range(3, 0));
      if (!m_held && $urandom_range(3, 0) != 0) rc = C_START;
      rd  = 1'($urandom);
      rs  = 1'($urandom);
      rdv = 16'($urandom_range(4, 0));
      run_cmd(rc, rd, rdv, rs, da);
      gap = $urandom_range(2, 0);
      idle_gap(gap);
    end

    if (!m_held) run_cmd(C_START, 1'b0, 16'd1, 1'b1, da);
    cmd_valid = 1'b1;
    cmd = C_WRITE;
    cmd_data = 1'b0;
    dbl_clock_divisor = 16'd5;
    sda_in = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) cmd_valid = 1'b0;
    end
    check7("pre_reset_bit2", {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_rx});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_held = 1'b0;
    m_rx = 1'b0;
    @(negedge clk);
    check7("post_reset", 7'b0000010);
    run_cmd(C_STOP, 1'b0, 16'd2, 1'b1, da);
    check("idle_stop_no_done", da, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
